// File: rtl/conv_pkg.sv
// Shared definitions for the streaming 3x3 convolution: FSM encoding,
// coefficient count, reset-default Gaussian kernel and accumulator sizing.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int N_COEF = 9;

  // 1/16 Gaussian kernel in raster order, loaded on reset.
  function automatic int def_coef(input int idx);
    case (idx)
      0, 2, 6, 8: def_coef = 1;
      4:          def_coef = 4;
      default:    def_coef = 2;
    endcase
  endfunction

  // Nine products of DATA_W+COEF_W+1 bits need four extra bits of headroom.
  function automatic int acc_width(input int dw, input int cw);
    acc_width = dw + cw + 5;
  endfunction

endpackage

// File: rtl/conv_line_buf.sv
// IMG_W-deep pixel delay line: dout is the value pushed DEPTH enables ago.
module conv_line_buf #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (en) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv2d_stream.sv
// Streaming VALID 3x3 convolution over a raster pixel stream with two-stage
// multiply / round-saturate pipeline and ready/valid flow control.
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int FRAC_BITS = 4,
  parameter int OUT_W     = 16
) (
  input  logic                     clk,
  input  logic                     in_st,
  input  logic                     start,
  input  logic                     relu_en,
  output logic                     busy,
  input  logic                     coef_we,
  input  logic [3:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_din,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic [DATA_W-1:0]        pix_din,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  dout,
  output logic                     out_last,
  output logic                     frame_done
);

  localparam int ACC_W  = acc_width(DATA_W, COEF_W);
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [EXT_W-1:0] OMAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] OMIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic signed [ACC_W-1:0] round_fn(input logic signed [ACC_W-1:0] v);
    round_fn = (v + HALF) >>> FRAC_BITS;
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_fn(input logic signed [ACC_W-1:0] v);
    logic signed [EXT_W-1:0] e;
    e = EXT_W'(v);
    if (e > OMAX)      sat_fn = OMAX[OUT_W-1:0];
    else if (e < OMIN) sat_fn = OMIN[OUT_W-1:0];
    else               sat_fn = e[OUT_W-1:0];
  endfunction

  state_e                    state_q, state_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic                      relu_q, relu_d;
  logic                      frame_done_q, frame_done_d;
  logic signed [COEF_W-1:0]  coef_q [N_COEF];
  logic signed [COEF_W-1:0]  coef_d [N_COEF];
  logic [DATA_W-1:0]         win_q [N_COEF];
  logic [DATA_W-1:0]         win_d [N_COEF];
  logic [DATA_W-1:0]         lb0_out, lb1_out;

  logic signed [PROD_W-1:0]  prod_p1_q [N_COEF];
  logic signed [PROD_W-1:0]  prod_p1_d [N_COEF];
  logic                      vld_p1_q, vld_p1_d;
  logic                      last_p1_q, last_p1_d;
  logic signed [ACC_W-1:0]   sum_p1;
  logic signed [OUT_W-1:0]   res_p1;
  logic signed [OUT_W-1:0]   dout_p2_q, dout_p2_d;
  logic                      vld_p2_q, vld_p2_d;
  logic                      last_p2_q, last_p2_d;

  logic adv, acc, complete, is_final;

  // A result stuck at the output freezes the whole pipeline and the input.
  assign adv       = !(vld_p2_q && !out_ready);
  assign pix_ready = adv && (state_q == ST_FILL || state_q == ST_RUN);
  assign acc       = pix_valid && pix_ready;
  assign is_final  = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
  assign complete  = acc && (state_q == ST_RUN) && (col_q >= COL_W'(2));

  conv_line_buf #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb0 (
    .clk  (clk),
    .en   (acc),
    .din  (pix_din),
    .dout (lb0_out)
  );

  conv_line_buf #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb1 (
    .clk  (clk),
    .en   (acc),
    .din  (lb0_out),
    .dout (lb1_out)
  );

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    relu_d       = relu_q;
    frame_done_d = 1'b0;
    coef_d       = coef_q;
    if (state_q == ST_IDLE && coef_we && coef_addr <= 4'd8) coef_d[coef_addr] = coef_din;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FILL;
          relu_d  = relu_en;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ST_FILL: begin
        if (acc && row_q == ROW_W'(2) && col_q == COL_W'(1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (acc && is_final) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (vld_p2_q && out_ready && last_p2_q) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (acc) begin
      if (col_q == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = is_final ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Stage 0: new window column = two line-buffer taps plus incoming pixel.
  always_comb begin
    win_d = win_q;
    if (acc) begin
      for (int i = 0; i < 3; i++) begin
        win_d[i*3+0] = win_q[i*3+1];
        win_d[i*3+1] = win_q[i*3+2];
      end
      win_d[2] = lb1_out;
      win_d[5] = lb0_out;
      win_d[8] = pix_din;
    end
  end

  // Stage 1: nine signed products of the completed window.
  always_comb begin
    prod_p1_d = prod_p1_q;
    vld_p1_d  = vld_p1_q;
    last_p1_d = last_p1_q;
    if (adv) begin
      vld_p1_d  = complete;
      last_p1_d = complete && is_final;
      if (complete) begin
        for (int k = 0; k < N_COEF; k++)
          prod_p1_d[k] = PROD_W'($signed({1'b0, win_d[k]})) * PROD_W'(coef_q[k]);
      end
    end
  end

  // Stage 2: accumulate, round, saturate, optional ReLU.
  always_comb begin
    sum_p1 = '0;
    for (int k = 0; k < N_COEF; k++) sum_p1 = sum_p1 + ACC_W'(prod_p1_q[k]);
    res_p1 = sat_fn(round_fn(sum_p1));
    if (relu_q && res_p1 < 0) res_p1 = '0;
    dout_p2_d = dout_p2_q;
    vld_p2_d  = vld_p2_q;
    last_p2_d = last_p2_q;
    if (adv) begin
      vld_p2_d  = vld_p1_q;
      last_p2_d = vld_p1_q && last_p1_q;
      if (vld_p1_q) dout_p2_d = res_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_st) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      relu_q       <= 1'b0;
      frame_done_q <= 1'b0;
      vld_p1_q     <= 1'b0;
      last_p1_q    <= 1'b0;
      vld_p2_q     <= 1'b0;
      last_p2_q    <= 1'b0;
      dout_p2_q    <= '0;
      for (int k = 0; k < N_COEF; k++) coef_q[k] <= COEF_W'(def_coef(k));
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      relu_q       <= relu_d;
      frame_done_q <= frame_done_d;
      vld_p1_q     <= vld_p1_d;
      last_p1_q    <= last_p1_d;
      vld_p2_q     <= vld_p2_d;
      last_p2_q    <= last_p2_d;
      dout_p2_q    <= dout_p2_d;
      coef_q       <= coef_d;
    end
  end

  always_ff @(posedge clk) begin
    win_q     <= win_d;
    prod_p1_q <= prod_p1_d;
  end

  assign busy       = (state_q != ST_IDLE);
  assign out_valid  = vld_p2_q;
  assign out_last   = last_p2_q;
  assign dout       = dout_p2_q;
  assign frame_done = frame_done_q;

endmodule
